adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
Sequences the two LTC1864 ADC chains (pot and motor current, 4 devices each, shared timing) from a single clock. Each conversion is a conv pulse followed by a 16-bit serial readout. The block oversamples 2^AVG_LOG2 conversions per channel and publishes averaged pot/cur words with a valid strobe. It also provides a handshake-driven snapshot of the current values for synchronous readout by the register file.

Parameters:
CLK_DIV, 4, sclk half-period in clk cycles (>=1)
CONV_CYCLES, 200, conv-high duration in clk cycles (>=1), covers tCONV
AVG_LOG2, 2, log2 of conversions averaged per published frame (0..4)

Ports:
clk  in  1  block clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = run continuous scan frames
snap_req  in  1  one-cycle request to latch current values (already in clk domain)
miso_pot  in  4  serial data from pot ADCs, bit i = channel i+1
miso_cur  in  4  serial data from current ADCs, bit i = channel i+1
sclk  out  2  [0] pot chain, [1] cur chain; both driven identically
conv  out  2  [0] pot chain, [1] cur chain; both driven identically
pot_data  out  64  averaged pot values, [16*i+15:16*i] = channel i+1
cur_data  out  64  averaged current values, same packing
data_valid  out  1  one-cycle pulse when pot_data/cur_data update
snap_cur  out  64  cur_data captured on snap_req
snap_ack  out  1  one-cycle pulse, cycle after snap_req
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (sync, active-high; dominates every other input): state IDLE; sclk=0, conv=0, pot_data=0, cur_data=0, snap_cur=0, data_valid=0, snap_ack=0, busy=0; accumulators, sample counter and shift registers cleared. Reset asserted mid-operation: all outputs return to their reset values on the next clk edge, and no partial data is published.
- States: IDLE, CONV, SHIFT, ACC, DONE.
- IDLE: if enable=1 at edge, go to CONV. conv goes 1 on the following cycle, and the CONV counter loads CONV_CYCLES.
- CONV: conv=1 for exactly CONV_CYCLES cycles. sclk is held 0. Then conv goes 0 and the state moves to SHIFT.
- SHIFT: lasts 32*CLK_DIV cycles.
  - sclk starts low and toggles every CLK_DIV cycles, giving 16 full periods.
  - On each 0->1 sclk transition cycle, all 8 miso bits are shifted into per-channel 16-bit registers, MSB first.
  - After the 16th rising edge and the final low half-period, go to ACC. sclk is 0 on exit.
- ACC: one cycle.
  - acc[ch] += shift[ch] for all 8 channels. Accumulator width is 16+AVG_LOG2, so it cannot overflow.
  - sample_cnt increments.
  - If sample_cnt reaches 2^AVG_LOG2, go to DONE.
  - Otherwise, if enable=1, go to CONV.
  - Otherwise go to IDLE, discarding the accumulators (cleared), with no data_valid.
- DONE: one cycle.
  - pot_data/cur_data are loaded with acc >> AVG_LOG2 (truncation, no rounding).
  - data_valid=1 for this cycle only.
  - Accumulators and counter are cleared.
  - Next state is CONV if enable=1, else IDLE.
- enable is sampled only in IDLE, ACC and DONE. Deasserting it during CONV/SHIFT completes the current conversion.
- Timing:
  - Per-conversion period is CONV_CYCLES + 32*CLK_DIV + 1 cycles; 329 with the defaults.
  - If enable rises in IDLE at cycle 0, data_valid is high at cycle 1 + 2^AVG_LOG2*329; 1317 with the defaults.
  - Continuous frames follow with no gap beyond the DONE cycle.
- Snapshot handshake:
  - When snap_req=1 at an edge, snap_cur takes the cur_data value present in that cycle. If DONE updates cur_data on the same edge, the pre-update value is captured.
  - snap_ack=1 on the following cycle.
  - Back-to-back snap_req pulses each produce an ack; snap_ack stays high while snap_req is held.
  - Snapshot works in any state, including IDLE.
- AVG_LOG2=0: DONE follows every ACC, and data equals the raw conversion.

Test Plan:
- Reset, then hold enable=0 for 100 cycles -> all outputs 0, busy=0, sclk/conv never toggle.
- Set AVG_LOG2=0 with an ADC model returning 0xA5C3 on pot ch1 and 0x1234 on cur ch4; raise enable at cycle 0 -> conv high cycles 1..200, 16 sclk periods of 8 cycles, data_valid at cycle 330, pot_data[15:0]=0xA5C3, cur_data[63:48]=0x1234.
- Defaults, cur ch1 samples 0x1000, 0x1002, 0x1004, 0x1007 -> data_valid at cycle 1317, cur_data[15:0]=0x1003 (truncated). Repeat with four 0xFFFF samples -> 0xFFFF, no overflow.
- Drop enable during the 2nd SHIFT of a frame -> conversion completes, then ACC -> IDLE with busy=0 and no data_valid. Re-enable -> next frame averages only fresh samples.
- Assert snap_req in the same cycle as data_valid (old cur_data=0x0100, new=0x0200) -> snap_cur holds 0x0100 and snap_ack pulses next cycle. snap_req one cycle later -> snap_cur=0x0200.
- Assert reset at SHIFT cycle 50 -> next cycle sclk=0, conv=0, busy=0, data=0. After release with enable=1, a full frame runs with correct timing.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for the pot and motor-current LTC1864 chains (4 ADCs each).
// Runs conv pulse + 16-bit readout per conversion, oversamples 2^AVG_LOG2
// conversions per frame and publishes truncated averages with a valid strobe.
// Also offers a one-cycle snapshot handshake of the current words.
module adc_scan_sequencer #(
    parameter int CLK_DIV     = 4,
    parameter int CONV_CYCLES = 200,
    parameter int AVG_LOG2    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        snap_req,
    input  logic [3:0]  miso_pot,
    input  logic [3:0]  miso_cur,
    output logic [1:0]  sclk,
    output logic [1:0]  conv,
    output logic [63:0] pot_data,
    output logic [63:0] cur_data,
    output logic        data_valid,
    output logic [63:0] snap_cur,
    output logic        snap_ack,
    output logic        busy
);

    localparam int AW    = 16 + AVG_LOG2;
    localparam int CW    = $clog2(CONV_CYCLES + 1);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NSAMP = 1 << AVG_LOG2;

    localparam logic [CW-1:0]     CONV_LOAD = CW'(CONV_CYCLES);
    localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [AVG_LOG2:0] LAST_SAMP = (AVG_LOG2 + 1)'(NSAMP - 1);

    typedef enum logic [2:0] {IDLE, CONV, SHIFT, ACC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         conv_cnt;
    logic [DW-1:0]         div_cnt;
    logic [4:0]            half_cnt;
    logic [AVG_LOG2:0]     sample_cnt;
    logic                  sclk_r;
    logic                  conv_r;
    logic [7:0][15:0]      shreg;
    logic [7:0][AW-1:0]    acc;
    logic [7:0]            miso_all;

    // channels 0..3 are the pot chain, 4..7 the current chain
    assign miso_all = {miso_cur, miso_pot};
    assign sclk     = {2{sclk_r}};
    assign conv     = {2{conv_r}};
    assign busy     = (state != IDLE);

    // Scan FSM: conversion timing, serial capture, accumulation and publish.
    // data_valid is high during DONE; the averaged words land on the edge
    // that closes DONE, so a snapshot taken in the DONE cycle sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            conv_cnt   <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            sample_cnt <= '0;
            sclk_r     <= 1'b0;
            conv_r     <= 1'b0;
            shreg      <= '0;
            acc        <= '0;
            pot_data   <= '0;
            cur_data   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= CONV;
                        conv_r   <= 1'b1;
                        conv_cnt <= CONV_LOAD;
                    end
                end
                CONV: begin
                    if (conv_cnt == CW'(1)) begin
                        conv_r   <= 1'b0;
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        half_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 1'b1;
                        sclk_r   <= ~sclk_r;
                        // capture on the low-to-high sclk transition, MSB first
                        if (!sclk_r) begin
                            for (int ch = 0; ch < 8; ch++)
                                shreg[ch] <= {shreg[ch][14:0], miso_all[ch]};
                        end
                        // last half-period done: the toggle returns sclk to 0
                        if (half_cnt == 5'd31)
                            state <= ACC;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ACC: begin
                    if (sample_cnt != LAST_SAMP && !enable) begin
                        // partial frame abandoned: nothing is published
                        acc        <= '0;
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end else begin
                        for (int ch = 0; ch < 8; ch++)
                            acc[ch] <= acc[ch] + AW'(shreg[ch]);
                        sample_cnt <= sample_cnt + 1'b1;
                        if (sample_cnt == LAST_SAMP) begin
                            state      <= DONE;
                            data_valid <= 1'b1;
                        end else begin
                            state    <= CONV;
                            conv_r   <= 1'b1;
                            conv_cnt <= CONV_LOAD;
                        end
                    end
                end
                DONE: begin
                    for (int ch = 0; ch < 4; ch++) begin
                        pot_data[16*ch +: 16] <= 16'(acc[ch]   >> AVG_LOG2);
                        cur_data[16*ch +: 16] <= 16'(acc[ch+4] >> AVG_LOG2);
                    end
                    acc        <= '0;
                    sample_cnt <= '0;
                    if (enable) begin
                        state    <= CONV;
                        conv_r   <= 1'b1;
                        conv_cnt <= CONV_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot handshake: capture cur_data as seen this cycle, ack next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_cur <= '0;
            snap_ack <= 1'b0;
        end else begin
            snap_ack <= snap_req;
            if (snap_req)
                snap_cur <= cur_data;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: u0 uses default parameters, u1 AVG_LOG2=0.
// Each instance has its own behavioural ADC model and frame-average model.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, snap_req;
    logic [3:0]  miso_pot [2];
    logic [3:0]  miso_cur [2];
    logic [1:0]  sclk_o [2];
    logic [1:0]  conv_o [2];
    logic [63:0] pot_o [2];
    logic [63:0] cur_o [2];
    logic [63:0] snap_o [2];
    logic        dv_o [2];
    logic        ack_o [2];
    logic        busy_o [2];

    always #5 clk = ~clk;

    adc_scan_sequencer u0 (
        .clk(clk), .reset(reset), .enable(enable), .snap_req(snap_req),
        .miso_pot(miso_pot[0]), .miso_cur(miso_cur[0]),
        .sclk(sclk_o[0]), .conv(conv_o[0]), .pot_data(pot_o[0]), .cur_data(cur_o[0]),
        .data_valid(dv_o[0]), .snap_cur(snap_o[0]), .snap_ack(ack_o[0]), .busy(busy_o[0])
    );

    adc_scan_sequencer #(.AVG_LOG2(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .snap_req(snap_req),
        .miso_pot(miso_pot[1]), .miso_cur(miso_cur[1]),
        .sclk(sclk_o[1]), .conv(conv_o[1]), .pot_data(pot_o[1]), .cur_data(cur_o[1]),
        .data_valid(dv_o[1]), .snap_cur(snap_o[1]), .snap_ack(ack_o[1]), .busy(busy_o[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0 = 0;
    bit timing_on = 0;

    // ADC / frame model state
    logic [15:0]  sq   [2][8][$];   // forced sample values, consumed per conversion
    logic [15:0]  pend [2][8][$];   // completed conversions of the open frame
    logic [15:0]  word [2][8];
    int           fall [2];
    logic         pconv [2];
    logic         psclk [2];
    bit           chk_pend [2];
    logic [127:0] exp_vec [2];
    int           dv_cnt [2];

    typedef struct {
        int         r;
        int         inst;
        logic       en;
        logic [1:0] conv;
        logic [1:0] sclk;
        logic       dv;
        logic       busy;
    } row_t;
    row_t rows[$];

    function automatic int al(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // frame period from idle start: 2^AVG conversions of (200 + 32*4 + 1) plus DONE
    function automatic int per(int k);
        return (1 << al(k)) * (200 + 32 * 4 + 1) + 1;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc - t0, act, exp);
        end
    endtask

    task automatic monitor();
        for (int k = 0; k < 2; k++) begin
            if (chk_pend[k]) begin
                chk_pend[k] = 0;
                chk($sformatf("avg_data_u%0d", k), {cur_o[k], pot_o[k]}, exp_vec[k]);
            end
            if (conv_o[k][0] === 1'b1 && pconv[k] !== 1'b1) begin
                for (int ch = 0; ch < 8; ch++)
                    word[k][ch] = (sq[k][ch].size() > 0) ? sq[k][ch].pop_front() : 16'($urandom);
                fall[k] = 0;
            end
            if (sclk_o[k][0] === 1'b0 && psclk[k] === 1'b1) begin
                fall[k]++;
                if (fall[k] == 16)
                    for (int ch = 0; ch < 8; ch++) pend[k][ch].push_back(word[k][ch]);
            end
            pconv[k] = conv_o[k][0];
            psclk[k] = sclk_o[k][0];
            for (int ch = 0; ch < 8; ch++) begin
                logic b;
                b = (fall[k] < 16) ? word[k][ch][15 - fall[k]] : 1'b0;
                if (ch < 4) miso_pot[k][ch] = b;
                else        miso_cur[k][ch-4] = b;
            end
            if (dv_o[k] === 1'b1) begin
                dv_cnt[k]++;
                if (timing_on)
                    chk($sformatf("dv_phase_u%0d", k), 128'((cyc - t0) % per(k)), 128'(0));
                chk($sformatf("frame_len_u%0d", k), 128'(pend[k][0].size()), 128'(1 << al(k)));
                for (int ch = 0; ch < 8; ch++) begin
                    int s = 0;
                    foreach (pend[k][ch][i]) s += int'(pend[k][ch][i]);
                    exp_vec[k][16*ch +: 16] = 16'(s >> al(k));
                    pend[k][ch].delete();
                end
                chk_pend[k] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            chk_pend[k] = 0;
            for (int ch = 0; ch < 8; ch++) pend[k][ch].delete();
        end
    endtask

    task automatic apply_rows(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            while (cyc - t0 < rows[i].r) tick();
            enable = rows[i].en;
            chk($sformatf("shape_u%0d_r%0d", rows[i].inst, rows[i].r),
                128'({conv_o[rows[i].inst], sclk_o[rows[i].inst], dv_o[rows[i].inst], busy_o[rows[i].inst]}),
                128'({rows[i].conv, rows[i].sclk, rows[i].dv, rows[i].busy}));
        end
    endtask

    task automatic wait_dv1(string nm);
        int n = 0;
        do begin tick(); n++; end while (dv_o[1] !== 1'b1 && n < 400);
        chk(nm, 128'(dv_o[1]), 128'(1));
    endtask

    task automatic run_to(int r);
        while (cyc - t0 < r) tick();
    endtask

    initial begin
        int d0, d1, n;

        rows.push_back(row_t'{0,    0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
        rows.push_back(row_t'{0,    1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0});
        rows.push_back(row_t'{1,    0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{1,    1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{200,  0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{201,  0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{201,  1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{204,  0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{205,  0, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1});
        rows.push_back(row_t'{208,  1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1});
        rows.push_back(row_t'{209,  0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{325,  1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1});
        rows.push_back(row_t'{328,  0, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1});
        rows.push_back(row_t'{329,  0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{329,  1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{330,  0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{330,  1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1});
        rows.push_back(row_t'{331,  1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{1316, 0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1});
        rows.push_back(row_t'{1317, 0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1});
        rows.push_back(row_t'{1318, 0, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1});

        for (int k = 0; k < 2; k++) begin
            miso_pot[k] = '0; miso_cur[k] = '0; pconv[k] = 1'b0; psclk[k] = 1'b0;
            fall[k] = 16; dv_cnt[k] = 0; chk_pend[k] = 0; exp_vec[k] = '0;
            for (int ch = 0; ch < 8; ch++) word[k][ch] = '0;
        end

        // reset and idle
        reset = 1'b1; enable = 1'b0; snap_req = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_u%0d", k),
                {cur_o[k][63:0], pot_o[k][63:0]} | 128'({sclk_o[k], conv_o[k], dv_o[k], ack_o[k], busy_o[k]}),
                128'(0));
        reset = 1'b0;
        repeat (100) begin
            tick();
            for (int k = 0; k < 2; k++)
                chk($sformatf("idle_u%0d", k),
                    {cur_o[k], pot_o[k]} | 128'({sclk_o[k], conv_o[k], dv_o[k], busy_o[k], snap_o[k]}),
                    128'(0));
        end

        // directed timing and averaging frames
        sq[1][0].push_back(16'hA5C3);
        sq[1][7].push_back(16'h1234);
        sq[0][4].push_back(16'h1000); sq[0][4].push_back(16'h1002);
        sq[0][4].push_back(16'h1004); sq[0][4].push_back(16'h1007);
        repeat (4) sq[0][4].push_back(16'hFFFF);
        t0 = cyc; timing_on = 1;
        apply_rows(0, 17);
        chk("raw_pot_ch1_u1", 128'(pot_o[1][15:0]), 128'(16'hA5C3));
        chk("raw_cur_ch4_u1", 128'(cur_o[1][63:48]), 128'(16'h1234));
        apply_rows(18, 20);
        chk("avg_trunc_cur_ch1", 128'(cur_o[0][15:0]), 128'(16'h1003));
        run_to(2635);
        chk("avg_ffff_cur_ch1", 128'(cur_o[0][15:0]), 128'(16'hFFFF));

        // enable dropped during 2nd SHIFT of a frame
        run_to(2635 + 560);
        enable = 1'b0;
        d0 = dv_cnt[0];
        run_to(2635 + 657);
        chk("abort_acc_busy", 128'(busy_o[0]), 128'(1));
        tick();
        chk("abort_idle", 128'({busy_o[0], conv_o[0], sclk_o[0]}), 128'(0));
        for (int ch = 0; ch < 8; ch++) pend[0][ch].delete();
        run_to(2635 + 700);
        chk("abort_no_dv", 128'(dv_cnt[0] - d0), 128'(0));
        n = 0;
        while (busy_o[1] !== 1'b0 && n < 400) begin tick(); n++; end
        chk("u1_idle_after_drop", 128'(busy_o[1]), 128'(0));
        repeat (3) tick();

        // re-enable with random samples, continuous frames
        t0 = cyc; enable = 1'b1;
        d0 = dv_cnt[0]; d1 = dv_cnt[1];
        run_to(3953);
        chk("rand_frames_u0", 128'(dv_cnt[0] - d0), 128'(3));
        chk("rand_frames_u1", 128'(dv_cnt[1] - d1), 128'(11));

        // reset in the middle of a SHIFT
        run_to(4201);
        chk("pre_reset_busy", 128'(busy_o[0]), 128'(1));
        reset = 1'b1;
        tick();
        for (int k = 0; k < 2; k++)
            chk($sformatf("mid_reset_u%0d", k),
                {cur_o[k], pot_o[k]} | 128'({sclk_o[k], conv_o[k], dv_o[k], busy_o[k]}),
                128'(0));
        tick();
        clear_model();
        reset = 1'b0;
        t0 = cyc;
        d0 = dv_cnt[0];
        run_to(1318);
        chk("post_reset_frame", 128'(dv_cnt[0] - d0), 128'(1));

        // snapshot around a publish
        wait_dv1("snap_sync");
        sq[1][4].push_back(16'h0100);
        sq[1][4].push_back(16'h0200);
        wait_dv1("snap_old_frame");
        wait_dv1("snap_new_frame");
        chk("snap_pre_cur", 128'(cur_o[1][15:0]), 128'(16'h0100));
        snap_req = 1'b1;
        tick();
        chk("snap_old", 128'({ack_o[0], ack_o[1], snap_o[1][15:0]}), 128'({2'b11, 16'h0100}));
        tick();
        chk("snap_new", 128'({ack_o[0], ack_o[1], snap_o[1][15:0]}), 128'({2'b11, 16'h0200}));
        snap_req = 1'b0;
        tick();
        chk("snap_ack_low", 128'({ack_o[0], ack_o[1]}), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
